dmem_responder: RTL

- Handshaked data-memory responder: the target side of the CPU load/store path.
- Accepts one load or store request at a time and services it after a fixed, parameterised latency.
- Returns read data with RV32I byte/halfword lane selection and sign/zero extension.
- Serves as the slave behind the multi-cycle and pipelined cores, replacing the zero-latency combinational data memory.

---
 rtl/dmem_responder.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: handshaked RV32I data-memory target that services one load/store after LATENCY cycles.
// Build option DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses return rsp_err instead of being aligned down.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_illegal(input logic wr, input logic [2:0] f3);
        logic ill;
        case (f3)
            3'b000, 3'b001, 3'b010: ill = 1'b0;
            3'b100, 3'b101:         ill = wr;
            default:                ill = 1'b1;
        endcase
        return ill;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = lane[0];
            2'b10:   mis = (lane != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] sh);
        logic [31:0] r;
        case (f3)
            3'b000:  r = {{24{sh[7]}}, sh[7:0]};
            3'b001:  r = {{16{sh[15]}}, sh[15:0]};
            3'b010:  r = sh;
            3'b100:  r = {24'h000000, sh[7:0]};
            3'b101:  r = {16'h0000, sh[15:0]};
            default: r = 32'h00000000;
        endcase
        return r;
    endfunction

    logic [31:0]   mem_q [DEPTH_WORDS];

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          write_q, write_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;

    logic [1:0]    lane_s;
    logic          err_s;
    logic [AW-1:0] word_idx_s;
    logic [31:0]   shifted_s;
    logic [3:0]    mem_be_s;
    logic [31:0]   mem_wdata_s;
    logic          mem_we_s;
    logic          unused_addr_s;

    assign unused_addr_s = ^req_addr[31:AW+2];
    assign word_idx_s    = addr_q[AW+1:2];

    // Access decode from the latched request: lane alignment, error, byte enables, read shift.
    always_comb begin
        case (funct3_q[1:0])
            2'b01:   lane_s = {addr_q[1], 1'b0};
            2'b10:   lane_s = 2'b00;
            default: lane_s = addr_q[1:0];
        endcase
`ifdef DMEM_MISALIGN_TRAP_EN
        err_s = is_illegal(write_q, funct3_q) | is_misaligned(funct3_q, addr_q[1:0]);
`else
        err_s = is_illegal(write_q, funct3_q);
`endif
        case (funct3_q[1:0])
            2'b00: begin
                mem_be_s    = 4'b0001 << lane_s;
                mem_wdata_s = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                mem_be_s    = lane_s[1] ? 4'b1100 : 4'b0011;
                mem_wdata_s = {2{wdata_q[15:0]}};
            end
            default: begin
                mem_be_s    = 4'b1111;
                mem_wdata_s = wdata_q;
            end
        endcase
        shifted_s = mem_q[word_idx_s] >> {lane_s, 3'b000};
    end

    // Next-state and output logic of the IDLE/WAIT/RESP sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_we_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d     = req_write;
                    funct3_d    = req_funct3;
                    addr_d      = req_addr[AW+1:0];
                    wdata_d     = req_wdata;
                    cnt_d       = CNT_LOAD;
                    req_ready_d = 1'b0;
                    state_d     = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q != {CW{1'b0}}) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_s;
                    rsp_rdata_d = (write_q || err_s) ? 32'h00000000 : load_extend(funct3_q, shifted_s);
                    // A reset on the access edge must leave memory untouched.
                    mem_we_s    = write_q && !err_s && !rst;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // Control and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= {CW{1'b0}};
            write_q     <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= {(AW+2){1'b0}};
            wdata_q     <= 32'h00000000;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h00000000;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Byte-enabled memory write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be_s[b]) begin
                    mem_q[word_idx_s][8*b +: 8] <= mem_wdata_s[8*b +: 8];
                end
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
